// File: rtl/libMdlu.sv
// libMdlu command codes, fixed latency and FSM state type shared by the
// iterative multiply/divide unit and its users.
package libMdlu;

   localparam logic [1:0] MDLU_MULT     = 2'd0;
   localparam logic [1:0] MDLU_DIV      = 2'd1;
   localparam logic [1:0] MDLU_ZERO     = 2'd2;
   localparam logic [1:0] MDLU_RESERVED = 2'd3;

   // Accepting edge to the cycle done is visible, for MULT/DIV at WIDTH = 32
   localparam int MDLU_LATENCY = 34;

   typedef enum logic [2:0] {
      IDLE,
      MUL,
      DIV,
      FIX,
      DONE
   } mdlu_state_t;

endpackage

// File: rtl/mdlu_restoring_step.sv
// One restoring-divide iteration: shift in the next dividend bit, trial
// subtract the divisor, keep the difference when it does not borrow.
module mdlu_restoring_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             bit_in,
   input  logic [WIDTH:0]   divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic             q_bit
);

   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] diff;

   assign shifted  = {rem, bit_in};
   assign diff     = {1'b0, shifted} - {1'b0, divisor};
   assign q_bit    = ~diff[WIDTH+1];
   // The kept remainder is always below the divisor, so WIDTH bits suffice
   assign rem_next = q_bit ? WIDTH'(diff) : WIDTH'(shifted);

endmodule

// File: rtl/mdlu_iterative.sv
// Multi-cycle multiply/divide unit holding HI/LO (radix-2 shift-add, restoring
// divide). Define MDLU_UNSIGNED_EN to add the op_unsigned port (MULTU/DIVU).
module mdlu_iterative
   import libMdlu::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef MDLU_UNSIGNED_EN
   input  logic             op_unsigned,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   mdlu_state_t state, state_next;

   logic [CW-1:0]      cnt;
   logic [WIDTH:0]     mcand;       // multiplicand or divisor magnitude
   logic [WIDTH-1:0]   rem;         // product upper half or partial remainder
   logic [WIDTH-1:0]   quo;         // multiplier / product lower half or quotient
   logic [WIDTH-1:0]   a_q;
   logic               is_div_q, b_zero_q, neg_q, neg_r;

   logic               accept, is_signed, sign_a, sign_b, last_iter;
   logic [WIDTH:0]     mag_a, mag_b, mul_sum;
   logic [WIDTH-1:0]   step_rem;
   logic               step_q;
   logic [2*WIDTH-1:0] product;

`ifdef MDLU_UNSIGNED_EN
   assign is_signed = ~op_unsigned;
`else
   assign is_signed = 1'b1;
`endif

   assign accept = (state == IDLE) && start && (op != MDLU_RESERVED);

   // WIDTH+1-bit magnitudes so the most-negative operand cannot overflow
   assign sign_a = is_signed & a[WIDTH-1];
   assign sign_b = is_signed & b[WIDTH-1];
   assign mag_a  = sign_a ? ({(WIDTH+1){1'b0}} - {1'b1, a}) : {1'b0, a};
   assign mag_b  = sign_b ? ({(WIDTH+1){1'b0}} - {1'b1, b}) : {1'b0, b};

   assign last_iter = (cnt == CW'(WIDTH - 1));
   assign mul_sum   = {1'b0, rem} + (quo[0] ? mcand : {(WIDTH+1){1'b0}});
   assign product   = {rem, quo};

   mdlu_restoring_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem),
      .bit_in   (quo[WIDTH-1]),
      .divisor  (mcand),
      .rem_next (step_rem),
      .q_bit    (step_q)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      // NOTE: every output gets a default first so no latch is inferred.
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) begin
               unique case (op)
                  MDLU_MULT: state_next = MUL;
                  MDLU_DIV:  state_next = DIV;
                  default:   state_next = DONE;
               endcase
            end
         end
         MUL, DIV: begin
            busy = 1'b1;
            if (last_iter) state_next = FIX;
         end
         FIX: begin
            busy       = 1'b1;
            state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt      <= '0;
         mcand    <= '0;
         rem      <= '0;
         quo      <= '0;
         a_q      <= '0;
         is_div_q <= 1'b0;
         b_zero_q <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept && op == MDLU_ZERO) begin
                  hi <= '0;
                  lo <= '0;
               end else if (accept) begin
                  a_q      <= a;
                  is_div_q <= (op == MDLU_DIV);
                  b_zero_q <= (b == '0);
                  neg_q    <= sign_a ^ sign_b;
                  neg_r    <= sign_a;
                  cnt      <= '0;
                  rem      <= '0;
                  mcand    <= (op == MDLU_DIV) ? mag_b : mag_a;
                  quo      <= WIDTH'((op == MDLU_DIV) ? mag_a : mag_b);
               end
            end
            MUL: begin
               rem <= mul_sum[WIDTH:1];
               quo <= {mul_sum[0], quo[WIDTH-1:1]};
               cnt <= cnt + 1'b1;
            end
            DIV: begin
               rem <= step_rem;
               quo <= {quo[WIDTH-2:0], step_q};
               cnt <= cnt + 1'b1;
            end
            FIX: begin
               if (is_div_q && b_zero_q) begin
                  hi <= a_q;
                  lo <= '1;
               end else if (is_div_q) begin
                  hi <= neg_r ? -rem : rem;
                  lo <= neg_q ? -quo : quo;
               end else begin
                  {hi, lo} <= neg_q ? -product : product;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
